wb_uart: RTL and testbench
==========================

Name: wb_uart

Overview:
- Wishbone pipelined-mode slave UART: 8N1 serial transmit and receive with a programmable baud divisor.
- Attaches to one of the interconnect's I/O slave ports (5000H/6000H/7000H windows) as a downstream consumer of the CPU bus.
- The interconnect decodes the window and routes ack/dat back; this block decodes only its low register-select bits.
- TX is buffered by a small FIFO; RX is a single holding register with overrun and framing flags.

Parameters:
- TX_DEPTH, 4, TX FIFO entries; power of two, 2..16.
- DIV_RESET, 16'd434, clocks per bit after reset (50 MHz / 115200).

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- wb.adr  input  16  address; only adr[1:0] decoded.
- wb.dat_i  input  16  write data (dat_m).
- wb.dat_o  output  16  read data (dat_s).
- wb.cyc  input  1  cycle.
- wb.stb  input  1  strobe.
- wb.we  input  1  write enable.
- wb.stall  output  1  tied 0.
- wb.ack  output  1  acknowledge.
- rxd  input  1  serial in; asynchronous to clk.
- txd  output  1  serial out; idle high.

Behaviour:
- Reset (async, immediate) values:
  - Outputs: txd=1, ack=0, dat_o=0.
  - State: TX FIFO empty, TX and RX FSMs in IDLE, rx_valid=0, overrun=0, frame_err=0, divisor=DIV_RESET, rxd synchroniser flops=1.
- Request and ack:
  - A request is accepted when cyc&stb.
  - stall is always 0.
  - ack is registered: exactly one cycle after each accepted request, one ack per request. Back-to-back requests give back-to-back acks.
  - dat_o is registered and valid in the ack cycle; it holds its value otherwise.
- Registers (adr[1:0]):
  - 0 DATA
    - Write pushes dat_i[7:0]; if the FIFO is full the byte is dropped and still acked.
    - Read returns {8'h00, rx_byte} and clears rx_valid. If rx_valid=0 it returns the last byte with no side effect.
  - 1 STATUS (read-only)
    - Bits: bit0 rx_valid, bit1 tx_full, bit2 tx_empty (FIFO empty and TX IDLE), bit3 overrun, bit4 tx_busy, bit5 frame_err; other bits 0.
    - A read clears overrun and frame_err in the cycle after the ack, reporting the pre-clear value.
  - 2 DIVISOR: read/write, 16 bits. Values <2 are treated as 2. A change takes effect at the next bit boundary.
  - 3: reads 0, writes ignored.
- Bit timer: counts divisor-1 down to 0; one bit period = divisor clocks.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: pops the FIFO the cycle it sees it non-empty, then goes to START.
  - START: txd=0 for one bit.
  - DATA: 8 bits, LSB first.
  - STOP: txd=1 for one bit, then IDLE.
  - Push and pop in the same cycle keep the count unchanged.
- RX FSM (IDLE, START, DATA, STOP):
  - rxd passes through a 2-flop synchroniser.
  - IDLE: a falling edge goes to START.
  - START: samples at divisor/2 (integer division). If high, it is a glitch and the FSM returns to IDLE.
  - DATA: 8 samples, each one divisor apart, LSB first.
  - STOP: sampled one divisor later.
    - Stop=1: byte loaded to rx_byte and rx_valid=1. If rx_valid was already 1 and no DATA read occurs that cycle, set overrun and overwrite.
    - Stop=0: set frame_err and discard the byte.
  - If a DATA read and a new byte load coincide, the new byte wins, rx_valid stays 1, and overrun is not set.
  - Returns to IDLE after STOP; the next start edge is accepted immediately.
- cyc deasserted mid-stream: no pending state beyond the single registered ack, which is still issued.

Decomposition:
- Package wb_uart_pkg holds:
  - register offset constants (REG_DATA=2'd0, REG_STATUS=2'd1, REG_DIV=2'd2);
  - STATUS bit index constants;
  - typedef enum for uart_state_t {IDLE, START, DATA, STOP}, shared by the TX and RX FSMs.
- Sub-module uart_tx_fifo: synchronous FIFO with depth TX_DEPTH, 8 bits wide, async reset, push/pop/full/empty, count in log2(TX_DEPTH)+1 bits.
- The register file, TX FSM and RX FSM stay in wb_uart.

Test Plan:
- Write DIVISOR=4, write DATA=0x0055 → ack in each following cycle. txd: start 0, then 1,0,1,0,1,0,1,0 (LSB first), stop 1, each 4 clocks. STATUS bit2=1 after the stop bit.
- Six back-to-back DATA writes 0x01..0x06, TX_DEPTH=4, divisor 4 → 0x01 pops immediately and 0x02..0x05 fill the FIFO (tx_full=1). 0x06 is dropped but acked. txd carries exactly 0x01..0x05.
- Drive rxd frame 0xA3 at divisor 4 → STATUS reads 0x0005 (rx_valid, tx_empty). DATA read returns 0x00A3. The next STATUS read returns 0x0004.
- Two RX frames 0x11, 0x22 with no read → DATA returns 0x0022. STATUS bit3=1, and it is 0 on the following STATUS read.
- RX frame with stop bit 0 → STATUS bit5=1, rx_valid=0. A 1-clock low glitch on rxd produces no byte and no flag.
- Assert rst during a TX data bit with 2 bytes queued → txd=1 combinationally-immediately, FIFO empty, divisor=DIV_RESET. After release, a single write transmits normally.

Source files
------------

// File: rtl/wb_uart_pkg.sv
// Shared register map, status bit positions and FSM state encoding for wb_uart.
package wb_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int STAT_RX_VALID  = 0;
    localparam int STAT_TX_FULL   = 1;
    localparam int STAT_TX_EMPTY  = 2;
    localparam int STAT_OVERRUN   = 3;
    localparam int STAT_TX_BUSY   = 4;
    localparam int STAT_FRAME_ERR = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Divisors below 2 would leave no room for a half-bit sample point.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div < 16'd2) ? 16'd2 : div;
    endfunction

endpackage

// File: rtl/wb_uart_if.sv
// Wishbone pipelined-mode slave port of the UART (register-select slice only).
interface wb_uart_if;
    logic [15:0] adr;
    logic [15:0] dat_i;
    logic [15:0] dat_o;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        stall;
    logic        ack;

    modport master (output adr, dat_i, cyc, stb, we, input dat_o, stall, ack);
    modport slave  (input adr, dat_i, cyc, stb, we, output dat_o, stall, ack);
endinterface

// File: rtl/wb_uart_tx_fifo.sv
// Synchronous 8-bit FIFO queueing transmit bytes ahead of the TX shifter.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [7:0]               wdata_i,
    input  logic                     pop_i,
    output logic [7:0]               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/wb_uart.sv
// Wishbone UART: 8N1 TX (FIFO-buffered) and RX (single holding register) with
// a programmable baud divisor.
//   state | meaning
//   IDLE  | line idle; TX waits for a queued byte, RX waits for a falling edge
//   START | start bit; RX checks it at mid-bit and rejects glitches
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit; RX loads the byte or flags a framing error
module wb_uart
    import wb_uart_pkg::*;
#(
    parameter int unsigned TX_DEPTH  = 4,
    parameter logic [15:0] DIV_RESET = 16'd434
) (
    input  logic     clk,
    input  logic     rst,
    wb_uart_if.slave wb,
    input  logic     rxd,
    output logic     txd
);
    localparam int unsigned CW = $clog2(TX_DEPTH) + 1;
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_START = START;
    localparam logic [1:0] S_DATA  = DATA;
    localparam logic [1:0] S_STOP  = STOP;

    logic        req, data_wr, data_rd, stat_rd, div_wr;
    logic [1:0]  sel;
    logic        ack_q, clr_q;
    logic [15:0] dat_q, rd_mux, div_q, div_eff, status;
    logic        unused_adr;

    logic        fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_rdata;
    logic [CW-1:0] unused_tx_count;

    logic [1:0]  tx_state_q, tx_state_d;
    logic [15:0] tx_tmr_q, tx_tmr_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic [2:0]  tx_cnt_q, tx_cnt_d;
    logic        txd_q, txd_d;

    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic [1:0]  rx_state_q, rx_state_d;
    logic [15:0] rx_tmr_q, rx_tmr_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [2:0]  rx_cnt_q, rx_cnt_d;
    logic        rx_load, rx_ferr;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic        overrun_q, overrun_d;
    logic        ferr_q, ferr_d;

    assign req        = wb.cyc & wb.stb;
    assign sel        = wb.adr[1:0];
    assign data_wr    = req &  wb.we & (sel == REG_DATA);
    assign data_rd    = req & ~wb.we & (sel == REG_DATA);
    assign stat_rd    = req & ~wb.we & (sel == REG_STATUS);
    assign div_wr     = req &  wb.we & (sel == REG_DIV);
    assign unused_adr = ^wb.adr[15:2];
    assign div_eff    = eff_div(div_q);

    assign wb.stall = 1'b0;
    assign wb.ack   = ack_q;
    assign wb.dat_o = dat_q;
    assign txd      = txd_q;

    always_comb begin
        status = '0;
        status[STAT_RX_VALID]  = rx_valid_q;
        status[STAT_TX_FULL]   = fifo_full;
        status[STAT_TX_EMPTY]  = fifo_empty & (tx_state_q == S_IDLE);
        status[STAT_OVERRUN]   = overrun_q;
        status[STAT_TX_BUSY]   = (tx_state_q != S_IDLE);
        status[STAT_FRAME_ERR] = ferr_q;
    end

    always_comb begin
        rd_mux = '0;
        case (sel)
            REG_DATA:   rd_mux = {8'h00, rx_byte_q};
            REG_STATUS: rd_mux = status;
            REG_DIV:    rd_mux = div_q;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q <= 1'b0;
            clr_q <= 1'b0;
            dat_q <= '0;
            div_q <= DIV_RESET;
        end else begin
            ack_q <= req;
            clr_q <= stat_rd;
            if (req && !wb.we) dat_q <= rd_mux;
            if (div_wr) div_q <= wb.dat_i;
        end
    end

    uart_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (data_wr),
        .wdata_i (wb.dat_i[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (unused_tx_count)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tmr_d   = tx_tmr_q;
        tx_sh_d    = tx_sh_q;
        tx_cnt_d   = tx_cnt_q;
        txd_d      = txd_q;
        fifo_pop   = 1'b0;
        if (tx_state_q != S_IDLE && tx_tmr_q != '0) tx_tmr_d = tx_tmr_q - 16'd1;
        case (tx_state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_sh_d    = fifo_rdata;
                    tx_tmr_d   = div_eff - 16'd1;
                    txd_d      = 1'b0;
                    tx_state_d = S_START;
                end
            end
            S_START: if (tx_tmr_q == '0) begin
                txd_d      = tx_sh_q[0];
                tx_sh_d    = tx_sh_q >> 1;
                tx_cnt_d   = '0;
                tx_tmr_d   = div_eff - 16'd1;
                tx_state_d = S_DATA;
            end
            S_DATA: if (tx_tmr_q == '0) begin
                tx_tmr_d = div_eff - 16'd1;
                if (tx_cnt_q == 3'd7) begin
                    txd_d      = 1'b1;
                    tx_state_d = S_STOP;
                end else begin
                    txd_d    = tx_sh_q[0];
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_cnt_d = tx_cnt_q + 3'd1;
                end
            end
            S_STOP: if (tx_tmr_q == '0) tx_state_d = S_IDLE;
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= S_IDLE;
            tx_tmr_q   <= '0;
            tx_sh_q    <= '0;
            tx_cnt_q   <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tmr_q   <= tx_tmr_d;
            tx_sh_q    <= tx_sh_d;
            tx_cnt_q   <= tx_cnt_d;
            txd_q      <= txd_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tmr_d   = rx_tmr_q;
        rx_sh_d    = rx_sh_q;
        rx_cnt_d   = rx_cnt_q;
        rx_load    = 1'b0;
        rx_ferr    = 1'b0;
        if (rx_state_q != S_IDLE && rx_tmr_q != '0) rx_tmr_d = rx_tmr_q - 16'd1;
        case (rx_state_q)
            S_IDLE: if (rx_prev_q && !rx_s2_q) begin
                rx_tmr_d   = (div_eff >> 1) - 16'd1;
                rx_state_d = S_START;
            end
            S_START: if (rx_tmr_q == '0) begin
                if (rx_s2_q) begin
                    rx_state_d = S_IDLE;
                end else begin
                    rx_cnt_d   = '0;
                    rx_tmr_d   = div_eff - 16'd1;
                    rx_state_d = S_DATA;
                end
            end
            S_DATA: if (rx_tmr_q == '0) begin
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                rx_tmr_d = div_eff - 16'd1;
                if (rx_cnt_q == 3'd7) rx_state_d = S_STOP;
                else                  rx_cnt_d   = rx_cnt_q + 3'd1;
            end
            S_STOP: if (rx_tmr_q == '0) begin
                rx_load    = rx_s2_q;
                rx_ferr    = ~rx_s2_q;
                rx_state_d = S_IDLE;
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // A byte landing on the same edge as a DATA read replaces the one being read.
    always_comb begin
        rx_byte_d  = rx_load ? rx_sh_q : rx_byte_q;
        rx_valid_d = rx_load ? 1'b1 : (data_rd ? 1'b0 : rx_valid_q);
        overrun_d  = (rx_load && rx_valid_q && !data_rd) ? 1'b1 : (clr_q ? 1'b0 : overrun_q);
        ferr_d     = rx_ferr ? 1'b1 : (clr_q ? 1'b0 : ferr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_tmr_q   <= '0;
            rx_sh_q    <= '0;
            rx_cnt_q   <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_tmr_q   <= rx_tmr_d;
            rx_sh_q    <= rx_sh_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            ferr_q     <= ferr_d;
        end
    end

endmodule

// File: tb/tb_wb_uart.sv
// Directed bench for wb_uart: register table plus TX/RX/reset sequences.
module tb_wb_uart;
    import wb_uart_pkg::*;

    logic clk, rst, rxd, txd;
    int   n_vec = 0;
    int   n_err = 0;

    wb_uart_if wb();

    wb_uart #(.TX_DEPTH(4), .DIV_RESET(16'd434)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb),
        .rxd (rxd),
        .txd (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [15:0] wdat;
        logic [15:0] exp;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [15:0] a, input logic [15:0] d,
                       output logic [15:0] q);
        @(negedge clk);
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = w; wb.adr = a; wb.dat_i = d;
        @(negedge clk);
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        chk("ack", {31'b0, wb.ack}, 32'd1);
        q = wb.dat_o;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        logic [15:0] q;
        bus(1'b1, a, d, q);
    endtask

    task automatic rd(input string name, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] q;
        bus(1'b0, a, 16'h0000, q);
        chk(name, {16'h0, q}, {16'h0, exp});
    endtask

    // Checks every clock of a frame: bit values plus stability for exactly div clocks.
    task automatic tx_expect(input string name, input logic [7:0] b, input int div);
        logic [9:0] exp_f, got_f;
        logic       stable;
        int         t;
        exp_f = {1'b1, b, 1'b0};
        got_f = '0;
        t = 0;
        while (txd !== 1'b0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (txd !== 1'b0) begin
            chk({name, " start timeout"}, 32'd0, 32'd1);
            return;
        end
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            got_f[k] = txd;
            for (int j = 0; j < div; j++) begin
                if (txd !== got_f[k]) stable = 1'b0;
                @(negedge clk);
            end
        end
        chk(name, {21'b0, stable, got_f}, {21'b0, 1'b1, exp_f});
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop, input int div);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rxd = f[k];
            repeat (div - 1) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
        repeat (div + 2) @(negedge clk);
    endtask

    task automatic idle_check(input string name, input int cycles);
        logic saw_low;
        saw_low = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) saw_low = 1'b1;
        end
        chk(name, {31'b0, saw_low}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        vt[0]  = '{1'b0, 16'h0001, 16'h0000, 16'h0004};
        vt[1]  = '{1'b0, 16'h0002, 16'h0000, 16'h01B2};
        vt[2]  = '{1'b1, 16'h0002, 16'h1234, 16'h0000};
        vt[3]  = '{1'b0, 16'h7002, 16'h0000, 16'h1234};
        vt[4]  = '{1'b0, 16'h0003, 16'h0000, 16'h0000};
        vt[5]  = '{1'b1, 16'h0003, 16'hBEEF, 16'h0000};
        vt[6]  = '{1'b0, 16'h0003, 16'h0000, 16'h0000};
        vt[7]  = '{1'b0, 16'h0002, 16'h0000, 16'h1234};
        vt[8]  = '{1'b1, 16'h5002, 16'h0004, 16'h0000};
        vt[9]  = '{1'b0, 16'h0002, 16'h0000, 16'h0004};
        vt[10] = '{1'b0, 16'h6001, 16'h0000, 16'h0004};
        vt[11] = '{1'b1, 16'h0001, 16'h00FF, 16'h0000};
        vt[12] = '{1'b0, 16'h0001, 16'h0000, 16'h0004};

        rst = 1'b1; rxd = 1'b1;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.adr = '0; wb.dat_i = '0;
        #1;
        chk("reset txd",   {31'b0, txd},      32'd1);
        chk("reset ack",   {31'b0, wb.ack},   32'd0);
        chk("reset dat_o", {16'h0, wb.dat_o}, 32'd0);
        chk("stall",       {31'b0, wb.stall}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            if (vt[i].we) wr(vt[i].adr, vt[i].wdat);
            else          rd($sformatf("reg vec %0d", i), vt[i].adr, vt[i].exp);
        end

        wr(16'h0000, 16'h0055);
        tx_expect("tx 0x55", 8'h55, 4);
        rd("status after tx", 16'h0001, 16'h0004);

        fork
            begin
                @(negedge clk);
                wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b1; wb.adr = 16'h0000; wb.dat_i = 16'h0001;
                for (int i = 2; i <= 6; i++) begin
                    @(negedge clk);
                    chk("burst ack", {31'b0, wb.ack}, 32'd1);
                    wb.dat_i = 16'(i);
                end
                @(negedge clk);
                chk("burst ack", {31'b0, wb.ack}, 32'd1);
                wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
                @(negedge clk);
                chk("ack after burst", {31'b0, wb.ack}, 32'd0);
                rd("status full", 16'h0001, 16'h0012);
            end
            begin
                for (int i = 1; i <= 5; i++) tx_expect($sformatf("burst byte %0d", i), 8'(i), 4);
            end
        join
        idle_check("dropped byte not sent", 60);
        rd("status drained", 16'h0001, 16'h0004);

        rx_send(8'hA3, 1'b1, 4);
        rd("rx status", 16'h0001, 16'h0005);
        rd("rx data",   16'h0000, 16'h00A3);
        rd("rx status cleared", 16'h0001, 16'h0004);

        rx_send(8'h11, 1'b1, 4);
        rx_send(8'h22, 1'b1, 4);
        rd("overrun data",   16'h0000, 16'h0022);
        rd("overrun status", 16'h0001, 16'h000C);
        rd("overrun cleared", 16'h0001, 16'h0004);

        rx_send(8'h5A, 1'b0, 4);
        rd("frame err status", 16'h0001, 16'h0024);
        rd("frame byte discarded", 16'h0000, 16'h0022);
        rd("frame err cleared", 16'h0001, 16'h0004);

        @(negedge clk); rxd = 1'b0;
        @(negedge clk); rxd = 1'b1;
        repeat (20) @(negedge clk);
        rd("glitch ignored", 16'h0001, 16'h0004);

        wr(16'h0002, 16'h0000);
        wr(16'h0000, 16'h0096);
        tx_expect("tx div0 as 2", 8'h96, 2);
        wr(16'h0002, 16'h0004);

        wr(16'h0000, 16'h0000);
        wr(16'h0000, 16'h0000);
        wr(16'h0000, 16'h0000);
        t = 0;
        while (txd !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (12) @(negedge clk);
        chk("txd low mid data", {31'b0, txd}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("txd on async reset", {31'b0, txd},      32'd1);
        chk("dat_o on reset",     {16'h0, wb.dat_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd("status after reset", 16'h0001, 16'h0004);
        rd("div after reset",    16'h0002, 16'h01B2);
        wr(16'h0000, 16'h00A5);
        tx_expect("tx after reset", 8'hA5, 434);
        idle_check("no stale bytes", 500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
